// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester handshakes (port A = instruction
// fetch, port B = data load/store) and the single-port memory bus.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_read_address;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_output_data;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_read_address, mem_write_address, mem_write_data, mem_write_enable,
    input  mem_output_data
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable,
    output mem_output_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port block memory between port A
// (instruction fetch) and port B (data load/store).
// Each transaction runs IDLE -> ACCESS -> DONE: the grant is latched in IDLE,
// the memory is driven for exactly one ACCESS cycle (read-before-write), and
// the winner's ack pulses in DONE.
// Optional feature, macro MEMARB_IOPROT_EN: port A is denied access to the
// I/O word at IO_ADDR (no write, rdata forced to 0, err_a pulses with a_ack).
module mem_arbiter #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR   = 8'hFF,
  parameter int                PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic             busy,
  output logic             err_a
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

`ifdef MEMARB_IOPROT_EN
  localparam logic IOPROT_EN = 1'b1;
`else
  localparam logic IOPROT_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              grant_vld;
  logic              grant_port;
  logic              last_grant;
  logic              lat_port;
  logic              lat_we;
  logic              lat_prot;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Next-state and arbitration: only IDLE looks at the requests, so a request
  // raised while busy waits for the next IDLE and a losing request stays pending.
  always_comb begin
    state_d    = state_q;
    grant_vld  = 1'b0;
    grant_port = PORT_A;
    case (state_q)
      S_IDLE: begin
        if (bus.a_req && bus.b_req) begin
          grant_vld = 1'b1;
          if (PRIO_MODE == 1) grant_port = PORT_A;
          else                grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (bus.a_req) begin
          grant_vld  = 1'b1;
          grant_port = PORT_A;
        end else if (bus.b_req) begin
          grant_vld  = 1'b1;
          grant_port = PORT_B;
        end
        if (grant_vld) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latch the winner's request on grant; last_grant starts at B so the first
  // tie after reset goes to A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_B;
      lat_port   <= PORT_A;
      lat_we     <= 1'b0;
      lat_prot   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (grant_vld) begin
      last_grant <= grant_port;
      lat_port   <= grant_port;
      lat_we     <= (grant_port == PORT_A) ? bus.a_we    : bus.b_we;
      lat_addr   <= (grant_port == PORT_A) ? bus.a_addr  : bus.b_addr;
      lat_wdata  <= (grant_port == PORT_A) ? bus.a_wdata : bus.b_wdata;
      lat_prot   <= IOPROT_EN && (grant_port == PORT_A) && (bus.a_addr == IO_ADDR);
    end
  end

  // Capture read data during ACCESS, before the write lands; rdata holds
  // between transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else if (state_q == S_ACCESS) begin
      if (lat_port == PORT_A) a_rdata_q <= lat_prot ? '0 : bus.mem_output_data;
      else                    b_rdata_q <= bus.mem_output_data;
    end
  end

  // Write enable is decoded from the state register so an asynchronous reset
  // drops it immediately.
  assign bus.mem_read_address  = lat_addr;
  assign bus.mem_write_address = lat_addr;
  assign bus.mem_write_data    = lat_wdata;
  assign bus.mem_write_enable  = (state_q == S_ACCESS) && lat_we && !lat_prot;

  assign bus.a_ack   = (state_q == S_DONE) && (lat_port == PORT_A);
  assign bus.b_ack   = (state_q == S_DONE) && (lat_port == PORT_B);
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;
  assign busy        = (state_q != S_IDLE);

`ifdef MEMARB_IOPROT_EN
  assign err_a = (state_q == S_DONE) && (lat_port == PORT_A) && lat_prot;
`else
  assign err_a = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter. dut0 runs round-robin against
// a behavioural 256x32 memory; dut1 runs fixed priority against an
// address-echo memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy0, err_a0, busy1, err_a1;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus0();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus1();

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .IO_ADDR(8'hFF), .PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .err_a(err_a0)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .IO_ADDR(8'hFF), .PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .err_a(err_a1)
  );

  always #5 clk = ~clk;

  // Memory model for dut0, with a preload path for the bench.
  logic [31:0] mem0 [256];
  logic        pre_we   = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [31:0] pre_data = 32'h0;
  int          we_cnt0  = 0;

  always @(posedge clk) begin
    if (pre_we) mem0[pre_addr] <= pre_data;
    else if (bus0.mem_write_enable) mem0[bus0.mem_write_address] <= bus0.mem_write_data;
  end

  always @(posedge clk) begin
    if (bus0.mem_write_enable) we_cnt0 <= we_cnt0 + 1;
  end

  assign bus0.mem_output_data = mem0[bus0.mem_read_address];
  assign bus1.mem_output_data = {24'h0, bus1.mem_read_address};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] addr, input logic [31:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap, na, nb, we0;
    logic [31:0] exp_word, exp_rd;

    bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0; bus0.a_wdata = 0;
    bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0; bus0.b_wdata = 0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_wdata = 0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_busy", busy0, 0);
    check("rst_a_ack", bus0.a_ack, 0);
    check("rst_b_ack", bus0.b_ack, 0);
    check("rst_we", bus0.mem_write_enable, 0);
    check("rst_a_rdata", bus0.a_rdata, 0);
    check("rst_b_rdata", bus0.b_rdata, 0);
    check("rst_err_a", err_a0, 0);
    check("rst_addr", bus0.mem_write_address, 0);
    preload(8'h10, 32'h12345678);
    preload(8'h20, 32'hCAFE0001);
    preload(8'h30, 32'h55AA55AA);
    preload(8'hFF, 32'hABCD0000);
    rst = 1'b0;
    step();

    // Test 1: A read of 0x10
    bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 8'h10;
    step();
    check("t1_busy_access", busy0, 1);
    check("t1_ack_access", bus0.a_ack, 0);
    check("t1_rd_addr", bus0.mem_read_address, 32'h10);
    step();
    check("t1_busy_done", busy0, 1);
    check("t1_a_ack", bus0.a_ack, 1);
    check("t1_a_rdata", bus0.a_rdata, 32'h12345678);
    bus0.a_req = 0;
    step();
    check("t1_busy_idle", busy0, 0);
    check("t1_ack_gone", bus0.a_ack, 0);
    check("t1_rdata_hold", bus0.a_rdata, 32'h12345678);

    // Test 2: B write then B read back with req held
    we0 = we_cnt0;
    bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 8'h20; bus0.b_wdata = 32'hDEADBEEF;
    step(2);
    check("t2_wr_ack", bus0.b_ack, 1);
    check("t2_wr_old", bus0.b_rdata, 32'hCAFE0001);
    bus0.b_we = 0;
    step(3);
    check("t2_rd_ack", bus0.b_ack, 1);
    check("t2_rd_new", bus0.b_rdata, 32'hDEADBEEF);
    check("t2_mem", mem0[8'h20], 32'hDEADBEEF);
    check("t2_we_cycles", we_cnt0 - we0, 1);
    bus0.b_req = 0;
    step(2);

    // Test 3: round-robin, both requesting from reset
    reset_pulse();
    bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 8'h10;
    bus0.b_req = 1; bus0.b_we = 0; bus0.b_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin
        step();
        gap++;
      end while (!(bus0.a_ack || bus0.b_ack) && gap < 6);
      check("t3_gap", gap, (k == 0) ? 2 : 3);
      check("t3_who", {bus0.a_ack, bus0.b_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    check("t3_a_rdata", bus0.a_rdata, 32'h12345678);
    check("t3_b_rdata", bus0.b_rdata, 32'hDEADBEEF);
    bus0.a_req = 0; bus0.b_req = 0;
    step(3);

    // Test 4: fixed priority on dut1
    reset_pulse();
    bus1.a_req = 1; bus1.a_we = 0; bus1.a_addr = 8'h05;
    bus1.b_req = 1; bus1.b_we = 0; bus1.b_addr = 8'h06;
    na = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus1.a_ack) na++;
      if (bus1.b_ack) nb++;
    end
    check("t4_a_acks", na, 4);
    check("t4_b_acks", nb, 0);
    check("t4_a_rdata", bus1.a_rdata, 32'h05);
    bus1.a_req = 0;
    gap = 0;
    do begin
      step();
      gap++;
    end while (!bus1.b_ack && gap < 6);
    check("t4_b_served", bus1.b_ack, 1);
    check("t4_b_rdata", bus1.b_rdata, 32'h06);
    bus1.b_req = 0;
    step(2);

    // Test 5: reset during ACCESS of a B write
    bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 8'h30; bus0.b_wdata = 32'h11111111;
    step();
    check("t5_we_access", bus0.mem_write_enable, 1);
    rst = 1'b1;
    #1;
    check("t5_we_drop", bus0.mem_write_enable, 0);
    check("t5_busy_drop", busy0, 0);
    bus0.b_req = 0; bus0.b_we = 0;
    step();
    rst = 1'b0;
    check("t5_no_ack0", bus0.b_ack, 0);
    step();
    check("t5_no_ack1", bus0.b_ack, 0);
    check("t5_idle", busy0, 0);
    check("t5_mem", mem0[8'h30], 32'h55AA55AA);

    // Test 6: port A then port B write 0x1F to the I/O word
`ifdef MEMARB_IOPROT_EN
    exp_word = 32'hABCD0000;
    exp_rd   = 32'h0;
`else
    exp_word = 32'h0000001F;
    exp_rd   = 32'hABCD0000;
`endif
    bus0.a_req = 1; bus0.a_we = 1; bus0.a_addr = 8'hFF; bus0.a_wdata = 32'h1F;
    step(2);
    check("t6_a_ack", bus0.a_ack, 1);
`ifdef MEMARB_IOPROT_EN
    check("t6_err_a", err_a0, 1);
`else
    check("t6_err_a", err_a0, 0);
`endif
    check("t6_a_rdata", bus0.a_rdata, exp_rd);
    bus0.a_req = 0; bus0.a_we = 0;
    step();
    check("t6_err_clear", err_a0, 0);
    check("t6_mem_a", mem0[8'hFF], exp_word);
    bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 8'hFF; bus0.b_wdata = 32'h1F;
    step(2);
    check("t6_b_ack", bus0.b_ack, 1);
    check("t6_b_err", err_a0, 0);
    check("t6_b_rdata", bus0.b_rdata, exp_word);
    bus0.b_req = 0; bus0.b_we = 0;
    step();
    check("t6_mem_b", mem0[8'hFF], 32'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
